// File: rtl/motor_pkg.sv
// motor_pkg: shared command codes, FSM states and pin map
// for the two-motor H-bridge sequencer.
package motor_pkg;

  typedef enum logic [2:0] {
    CMD_STOP  = 3'd0,
    CMD_FWD   = 3'd1,
    CMD_REV   = 3'd2,
    CMD_LEFT  = 3'd3,
    CMD_RIGHT = 3'd4
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RAMP,
    ST_RUN,
    ST_BRAKE
  } st_e;

  function automatic logic cmd_ok(logic [2:0] c);
    return c <= 3'd4;
  endfunction

  // {zuo1,zuo2,you1,you2}
  function automatic logic [3:0] pin_map(cmd_e c);
    logic [3:0] p;
    p = 4'b0000;
    case (c)
      CMD_FWD:   p = 4'b1010;
      CMD_REV:   p = 4'b0101;
      CMD_LEFT:  p = 4'b0010;
      CMD_RIGHT: p = 4'b1000;
      default:   p = 4'b0000;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/pwm_gen.sv
// pwm_gen: free-running counter compared against a duty value,
// gated by an enable.
module pwm_gen #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_i,
  input  logic [PWM_BITS-1:0] duty_i,
  output logic                pwm_o
);

  logic [PWM_BITS-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_q + PWM_BITS'(1);
  end

  assign pwm_o = en_i && (cnt_q < duty_i);

endmodule

// File: rtl/motor_seq_ctrl.sv
// motor_seq_ctrl: arbitrated two-motor H-bridge sequencer
// with dead-time braking and soft-start PWM ramp.
module motor_seq_ctrl
  import motor_pkg::*;
#(
  parameter int PWM_BITS = 8,
  parameter int DEAD_CYC = 50000,
  parameter int RAMP_DIV = 2000,
  parameter int BEEP_DIV = 25000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                auto_valid,
  input  logic [2:0]          auto_cmd,
  input  logic                man_valid,
  input  logic [2:0]          man_cmd,
  input  logic [PWM_BITS-1:0] duty_max,
  output logic                zuo1,
  output logic                zuo2,
  output logic                you1,
  output logic                you2,
  output logic                en1,
  output logic                en2,
  output logic                beep,
  output logic                led1,
  output logic                busy,
  output logic [2:0]          cur_cmd
);

  localparam int DW = $clog2(DEAD_CYC + 1);
  localparam int RW = $clog2(RAMP_DIV + 1);
  localparam int BW = $clog2(BEEP_DIV + 1);

  st_e                 state_q, state_d;
  cmd_e                cur_q, cur_d;
  cmd_e                pend_q, pend_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [DW-1:0]       dead_q, dead_d;
  logic [RW-1:0]       ramp_q, ramp_d;
  logic [BW-1:0]       bcnt_q;
  logic                beep_q;
  logic                drive, beep_on, pwm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cur_q   <= CMD_STOP;
      pend_q  <= CMD_STOP;
      duty_q  <= '0;
      dead_q  <= '0;
      ramp_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      pend_q  <= pend_d;
      duty_q  <= duty_d;
      dead_q  <= dead_d;
      ramp_q  <= ramp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    pend_d  = pend_q;
    duty_d  = duty_q;
    dead_d  = dead_q;
    ramp_d  = ramp_q;
    if (auto_valid && cmd_ok(auto_cmd))
      pend_d = cmd_e'(auto_cmd);
    else if (man_valid && cmd_ok(man_cmd))
      pend_d = cmd_e'(man_cmd);
    unique case (state_q)
      ST_IDLE: begin
        if (pend_q != CMD_STOP) begin
          cur_d   = pend_q;
          duty_d  = '0;
          ramp_d  = '0;
          state_d = ST_RAMP;
        end
      end
      ST_RAMP: begin
        if (pend_q != cur_q) begin
          duty_d  = '0;
          dead_d  = '0;
          state_d = ST_BRAKE;
        end else if (duty_q == duty_max) begin
          state_d = ST_RUN;
        end else if (ramp_q == RW'(RAMP_DIV - 1)) begin
          ramp_d = '0;
          duty_d = (duty_q < duty_max) ? duty_q + PWM_BITS'(1)
                                       : duty_q - PWM_BITS'(1);
        end else begin
          ramp_d = ramp_q + RW'(1);
        end
      end
      ST_RUN: begin
        if (pend_q != cur_q) begin
          duty_d  = '0;
          dead_d  = '0;
          state_d = ST_BRAKE;
        end else if (duty_q != duty_max) begin
          ramp_d  = '0;
          state_d = ST_RAMP;
        end
      end
      ST_BRAKE: begin
        // pend is only looked at on expiry; changes never restart the count
        if (dead_q == DW'(DEAD_CYC - 1)) begin
          dead_d = '0;
          duty_d = '0;
          ramp_d = '0;
          cur_d  = pend_q;
          state_d = (pend_q == CMD_STOP) ? ST_IDLE : ST_RAMP;
        end else begin
          dead_d = dead_q + DW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (ena) begin
      state_d = ST_IDLE;
      cur_d   = CMD_STOP;
      pend_d  = CMD_STOP;
      duty_d  = '0;
      dead_d  = '0;
      ramp_d  = '0;
    end
  end

  assign drive   = (state_q != ST_BRAKE) && (cur_q != CMD_STOP);
  assign beep_on = drive && (cur_q == CMD_REV);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q <= '0;
      beep_q <= 1'b0;
    end else if (!beep_on || ena) begin
      bcnt_q <= '0;
      beep_q <= 1'b0;
    end else if (bcnt_q == BW'(BEEP_DIV - 1)) begin
      bcnt_q <= '0;
      beep_q <= ~beep_q;
    end else begin
      bcnt_q <= bcnt_q + BW'(1);
    end
  end

  pwm_gen #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (drive),
    .duty_i(duty_q),
    .pwm_o (pwm)
  );

  assign {zuo1, zuo2, you1, you2} = drive ? pin_map(cur_q) : 4'b0000;
  assign en1     = pwm;
  assign en2     = pwm;
  assign beep    = beep_q & beep_on;
  assign led1    = (state_q == ST_IDLE);
  assign busy    = (state_q == ST_RAMP) || (state_q == ST_BRAKE);
  assign cur_cmd = cur_q;

endmodule

// File: doc/motor_seq_ctrl.md
Name: motor_seq_ctrl

Overview:
- Sequences the car's two-motor H-bridge driver. Drives direction pins zuo1/zuo2/you1/you2, enables en1/en2, beeper and status LED.
- Arbitrates motion commands from two requesters: the obstacle-avoidance logic (auto, high priority) and the key panel (manual, low priority).
- On any change of motion, applies a dead-time brake, then a soft-start PWM ramp to the target duty.

Parameters:
- PWM_BITS, 8, width of PWM counter and duty values.
- DEAD_CYC, 50000, clk cycles with all bridge pins low between two different non-STOP motions and before STOP.
- RAMP_DIV, 2000, clk cycles per ±1 duty step during ramp.
- BEEP_DIV, 25000, half-period in clk cycles of the reversing-alarm tone.

Ports:
- clk, input, 1: system clock; the single clock of the block.
- rst_n, input, 1: asynchronous active-low reset.
- ena, input, 1: forced stop while 1.
- auto_valid, input, 1: auto command strobe.
- auto_cmd, input, 3: auto command code.
- man_valid, input, 1: manual command strobe.
- man_cmd, input, 3: manual command code.
- duty_max, input, PWM_BITS: target duty.
- zuo1, zuo2, you1, you2, output, 1 each: bridge direction pins.
- en1, en2, output, 1 each: bridge enables (PWM).
- beep, output, 1: beeper.
- led1, output, 1: 1 = stopped/idle.
- busy, output, 1: 1 in BRAKE or RAMP.
- cur_cmd, output, 3: motion currently applied.

Behaviour:
- Command codes: 0 STOP, 1 FWD, 2 REV, 3 LEFT, 4 RIGHT. Codes 5–7 are ignored and not captured.
- Pin map {zuo1,zuo2,you1,you2}:
  - FWD = 1010
  - REV = 0101
  - LEFT = 0010 (right wheel forward only)
  - RIGHT = 1000
  - STOP = 0000
- Reset (async, rst_n=0): all pins 0, en1=en2=0, beep=0, busy=0, led1=1, cur_cmd=STOP, pend=STOP, duty=0, all counters 0, state IDLE.
- Capture and arbitration:
  - Edge after a valid strobe loads pend.
  - auto_valid beats man_valid in the same cycle.
  - Captures are accepted in every state, so the latest request wins.
- FSM acts on pend != cur_cmd one cycle after capture.
  - IDLE (cur=STOP): pend non-STOP → load cur=pend, drive its pins, duty=0 → RAMP. First pin change is 2 edges after the strobe.
  - RAMP: every RAMP_DIV cycles, duty moves one step toward duty_max. duty==duty_max → RUN. pend != cur → BRAKE.
  - RUN: duty != duty_max → RAMP. pend != cur → BRAKE.
  - BRAKE: all four pins 0, en 0, duty=0 for exactly DEAD_CYC cycles.
    - At the end: if pend==STOP, set cur=STOP → IDLE. Otherwise load cur=pend, drive its pins → RAMP.
    - pend changing during BRAKE does not restart the count; the value at expiry is used.
- PWM:
  - Free-running PWM_BITS counter p.
  - en1=en2=(p < duty) when cur != STOP and state != BRAKE; otherwise 0.
  - duty=0 gives constant 0; duty=2^PWM_BITS-1 gives all but one slot high.
- beep: toggles every BEEP_DIV cycles while cur==REV and state != BRAKE; otherwise 0. The tone divider resets on entry to REV.
- led1 = 1 in IDLE, 0 otherwise.
- busy = 1 in BRAKE or RAMP.
- ena=1 (sampled each clk, overrides everything):
  - Next edge: all pins/en/beep 0, led1=1, cur=pend=STOP, duty=0, state IDLE. No dead time.
  - Strobes are ignored while ena=1.
- Dead-time and ramp counters saturate/reload; they never wrap.

Decomposition:
- Shared package motor_pkg:
  - Command code constants and pin-map function (cmd → 4-bit pattern).
  - FSM state encoding (IDLE, RAMP, RUN, BRAKE).
- Sub-module pwm_gen (PWM_BITS counter + compare, enable input). The rest stays in motor_seq_ctrl.

Test Plan (PWM_BITS=4, DEAD_CYC=4, RAMP_DIV=2, BEEP_DIV=3, duty_max=4):
- Reset, then man_valid cmd=1 → pins 1010 two edges later. duty rises 0→4 in 8 cycles, then RUN; en high 4 of every 16 cycles; busy 1 during ramp, led1 0.
- In RUN FWD, man cmd=2 → pins 0000 and en 0 for exactly 4 cycles, then pins 0101 with duty restarting at 0. beep toggles every 3 cycles after BRAKE.
- auto_valid cmd=0 and man_valid cmd=3 in the same cycle while in RUN FWD → STOP wins: 4-cycle BRAKE, then IDLE, led1=1, cur_cmd=0.
- During BRAKE, pend changes 3→4 → BRAKE still exactly 4 cycles, then pins 1000.
- Strobe cmd=6, then ena=1 mid-RAMP with a man strobe → cmd 6 ignored. Next edge: all outputs 0, led1=1; strobe ignored; after ena=0 the state stays IDLE.
- rst_n low mid-BRAKE, asynchronously between edges → outputs reach reset values immediately, without waiting for a clk edge.
